// File: rtl/dac_sample_scheduler_if.sv
// dac_sample_scheduler_if
//   Sample-request and DAC-frame handshake bundle between the producers,
//   the scheduler and the SPI DAC serializer.
//   master : the scheduler (consumes requests, drives dac_start/dac_data)
//   slave  : the environment (producers + serializer)
//   Signals: req0/req1 valid/data/ready, dac_start, dac_data, dac_busy.
interface dac_sample_scheduler_if #(
    parameter int DATA_W = 12
);
    logic              req0_valid;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              dac_start;
    logic [DATA_W-1:0] dac_data;
    logic              dac_busy;

    modport master (
        input  req0_valid, req0_data, req1_valid, req1_data, dac_busy,
        output req0_ready, req1_ready, dac_start, dac_data
    );

    modport slave (
        output req0_valid, req0_data, req1_valid, req1_data, dac_busy,
        input  req0_ready, req1_ready, dac_start, dac_data
    );
endinterface

// File: rtl/dac_sample_scheduler.sv
// dac_sample_scheduler
//   Paced two-requester scheduler in front of the SPI DAC serializer.
//   A rate divider produces the sample tick; on a tick with the serializer
//   idle, one requester is granted round-robin, its sample is latched and
//   a single-cycle dac_start launches the frame. The busy handshake is
//   supervised: a lost tick with pending data flags overrun, a serializer
//   that never raises busy flags fault.
// Ports:
//   clk_100MHz, rst     : clock, async active-high reset
//   enable, rate_div    : divider run / period (rate_div+1 cycles)
//   bus (master)        : request handshakes and DAC frame interface
//   grant_id            : requester of the last accepted sample
//   overrun, fault      : sticky status flags, cleared by flags_clr
module dac_sample_scheduler #(
    parameter int DATA_W  = 12,
    parameter int DIV_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk_100MHz,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [DIV_W-1:0]     rate_div,
    dac_sample_scheduler_if.master bus,
    output logic                 grant_id,
    output logic                 overrun,
    output logic                 fault,
    input  logic                 flags_clr
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

    state_t            state, state_n;
    logic [DIV_W-1:0]  cnt;
    logic [TW-1:0]     tcnt;
    logic              tick;
    logic              any_valid;
    logic              accept;
    logic              win;
    logic              timeout_hit;
    logic              ovr_set;
    logic              dac_start_q;
    logic [DATA_W-1:0] dac_data_q;

    // Divider: equality compare only, so a cnt above a freshly lowered
    // rate_div runs on to the natural wrap before matching again.
    assign tick = enable && (cnt == rate_div);

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst)          cnt <= '0;
        else if (!enable) cnt <= '0;
        else if (tick)    cnt <= '0;
        else              cnt <= cnt + DIV_W'(1);
    end

    assign any_valid = bus.req0_valid || bus.req1_valid;

    // Preferred requester is the one not granted last; fall back to the other.
    always_comb begin
        win = ~grant_id;
        if (grant_id == 1'b1) win = bus.req0_valid ? 1'b0 : 1'b1;
        else                  win = bus.req1_valid ? 1'b1 : 1'b0;
    end

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n     = state;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (tick && !bus.dac_busy && any_valid) begin
                    accept  = 1'b1;
                    state_n = LAUNCH;
                end
            end
            LAUNCH: state_n = WAIT_BUSY;
            WAIT_BUSY: begin
                if (bus.dac_busy) begin
                    state_n = WAIT_DONE;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    // This cycle's increment reaches TIMEOUT.
                    timeout_hit = 1'b1;
                    state_n     = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!bus.dac_busy) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst)                                      tcnt <= '0;
        else if (state == LAUNCH)                     tcnt <= '0;
        else if (state == WAIT_BUSY && !bus.dac_busy) tcnt <= tcnt + TW'(1);
    end

    assign bus.req0_ready = accept && (win == 1'b0);
    assign bus.req1_ready = accept && (win == 1'b1);

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            dac_start_q <= 1'b0;
            dac_data_q  <= '0;
            grant_id    <= 1'b1;
        end else begin
            dac_start_q <= accept;
            if (accept) begin
                dac_data_q <= win ? bus.req1_data : bus.req0_data;
                grant_id   <= win;
            end
        end
    end

    assign bus.dac_start = dac_start_q;
    assign bus.dac_data  = dac_data_q;

    // A tick that finds data waiting but cannot accept is a lost sample.
    assign ovr_set = tick && any_valid && (state != IDLE || bus.dac_busy);

    // Set has priority over clear for both sticky flags.
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
            fault   <= 1'b0;
        end else begin
            if (ovr_set)        overrun <= 1'b1;
            else if (flags_clr) overrun <= 1'b0;
            if (timeout_hit)    fault <= 1'b1;
            else if (flags_clr) fault <= 1'b0;
        end
    end
endmodule
